// File: rtl/add_accum_mc.sv
// ----------------------------------------------------------------------------
// add_accum_mc
//
// Multi-channel signed accumulator with a one-deep registered read port.
// Each channel keeps an AW = DATA_WIDTH+GUARD bit two's complement
// accumulator and a sticky overflow flag. Commands arrive on a valid/ready
// handshake. READ / READ_CLEAR return the selected accumulator saturated to
// DATA_WIDTH bits through a valid/ready output register.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   in_valid   in   command present
//   in_ready   out  command can be accepted (= !out_valid | out_ready)
//   control    in   [2:0] opcode
//   ch         in   [CH_BITS-1:0] target channel
//   add_in     in   [DATA_WIDTH-1:0] signed operand
//   out_valid  out  acc_out holds a read result
//   out_ready  in   consumer takes the result
//   acc_out    out  [DATA_WIDTH-1:0] saturated read result
//   ovf        out  [NUM_CH-1:0] sticky overflow flag per channel
//
// Opcodes
//   000 ACCUM       acc + add_in          (wraps, overflow -> ovf)
//   001 LOAD        add_in                (clears ovf)
//   010 HOLD        no change
//   011 COMPLEMENT  0 - acc               (wraps, overflow -> ovf)
//   100 SUB         acc - add_in          (wraps, overflow -> ovf)
//   101 CLEAR       0                     (clears ovf)
//   110 READ        emit saturated acc    (saturation -> ovf)
//   111 READ_CLEAR  emit saturated acc, then acc = 0, ovf = 0
// ----------------------------------------------------------------------------
module add_accum_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int GUARD      = 4,
    parameter int NUM_CH     = 2,
    parameter int CH_BITS    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            control,
    input  logic [CH_BITS-1:0]    ch,
    input  logic [DATA_WIDTH-1:0] add_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] acc_out,
    output logic [NUM_CH-1:0]     ovf
);

    localparam int AW = DATA_WIDTH + GUARD;

    typedef enum logic [2:0] {
        OP_ACCUM      = 3'b000,
        OP_LOAD       = 3'b001,
        OP_HOLD       = 3'b010,
        OP_COMPLEMENT = 3'b011,
        OP_SUB        = 3'b100,
        OP_CLEAR      = 3'b101,
        OP_READ       = 3'b110,
        OP_READ_CLEAR = 3'b111
    } op_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic signed [AW-1:0]   acc_q [NUM_CH];
    logic [NUM_CH-1:0]      ovf_q;
    logic                   out_valid_q;
    logic [DATA_WIDTH-1:0]  acc_out_q;

    // ------------------------------------------------------------------
    // Handshake and channel decode
    // ------------------------------------------------------------------
    op_e                    op;
    logic                   accept;
    logic                   ch_ok;
    logic [NUM_CH-1:0]      ch_hit;

    assign op       = op_e'(control);
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Out-of-range channels decode to no channel at all, so they are
    // accepted but touch nothing, and a read of them returns zero.
    assign ch_ok = (32'(ch) < $unsigned(NUM_CH));

    always_comb begin
        ch_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_hit[i] = ch_ok && (32'(ch) == $unsigned(i));
        end
    end

    // ------------------------------------------------------------------
    // Selected channel and arithmetic
    // ------------------------------------------------------------------
    logic signed [AW-1:0]   sel_acc;
    logic                   sel_ovf;
    logic signed [AW-1:0]   op_ext;
    logic signed [AW-1:0]   sum;
    logic signed [AW-1:0]   diff;
    logic signed [AW-1:0]   neg;
    logic                   ovf_add;
    logic                   ovf_sub;
    logic                   ovf_neg;

    always_comb begin
        sel_acc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_hit[i]) begin
                sel_acc = acc_q[i];
            end
        end
    end

    assign sel_ovf = |(ovf_q & ch_hit);
    assign op_ext  = {{GUARD{add_in[DATA_WIDTH-1]}}, add_in};

    assign sum  = sel_acc + op_ext;
    assign diff = sel_acc - op_ext;
    assign neg  = -sel_acc;

    // Signed overflow: same-sign operands giving a result of the other sign
    // (add), or opposite-sign operands whose result leaves the minuend's sign
    // (sub). Negation only overflows on the most negative value, which is the
    // one negative input that stays negative.
    assign ovf_add = (sel_acc[AW-1] == op_ext[AW-1]) && (sum[AW-1]  != sel_acc[AW-1]);
    assign ovf_sub = (sel_acc[AW-1] != op_ext[AW-1]) && (diff[AW-1] != sel_acc[AW-1]);
    assign ovf_neg = sel_acc[AW-1] && neg[AW-1];

    // ------------------------------------------------------------------
    // Read saturation: in range when the guard bits and the result sign bit
    // all agree.
    // ------------------------------------------------------------------
    logic [GUARD:0]         upper;
    logic                   in_range;
    logic [DATA_WIDTH-1:0]  sat_val;

    assign upper    = sel_acc[AW-1:DATA_WIDTH-1];
    assign in_range = (&upper) || !(|upper);

    always_comb begin
        sat_val = sel_acc[DATA_WIDTH-1:0];
        if (!in_range) begin
            sat_val = sel_acc[AW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    // ------------------------------------------------------------------
    // Next value of the selected channel
    // ------------------------------------------------------------------
    logic signed [AW-1:0]   acc_nxt;
    logic                   ovf_nxt;
    logic                   is_read;

    always_comb begin
        acc_nxt = sel_acc;
        ovf_nxt = sel_ovf;
        is_read = 1'b0;
        case (op)
            OP_ACCUM: begin
                acc_nxt = sum;
                ovf_nxt = sel_ovf || ovf_add;
            end
            OP_LOAD: begin
                acc_nxt = op_ext;
                ovf_nxt = 1'b0;
            end
            OP_HOLD: begin
            end
            OP_COMPLEMENT: begin
                acc_nxt = neg;
                ovf_nxt = sel_ovf || ovf_neg;
            end
            OP_SUB: begin
                acc_nxt = diff;
                ovf_nxt = sel_ovf || ovf_sub;
            end
            OP_CLEAR: begin
                acc_nxt = '0;
                ovf_nxt = 1'b0;
            end
            OP_READ: begin
                is_read = 1'b1;
                ovf_nxt = sel_ovf || !in_range;
            end
            OP_READ_CLEAR: begin
                is_read = 1'b1;
                acc_nxt = '0;
                ovf_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
            end
            ovf_q       <= '0;
            out_valid_q <= 1'b0;
            acc_out_q   <= '0;
        end else begin
            if (accept) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_hit[i]) begin
                        acc_q[i] <= acc_nxt;
                        ovf_q[i] <= ovf_nxt;
                    end
                end
            end

            // A new read takes priority over draining, which gives
            // back-to-back results without a bubble.
            if (accept && is_read) begin
                out_valid_q <= 1'b1;
                acc_out_q   <= ch_ok ? sat_val : '0;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign acc_out   = acc_out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_accum_mc.sv
// ----------------------------------------------------------------------------
// tb_add_accum_mc
//
// Scoreboard bench for add_accum_mc (DATA_WIDTH=16, GUARD=4, NUM_CH=2,
// CH_BITS=2 so channels 2 and 3 exercise the out-of-range path).
// Expected read results are pushed when a command is accepted and popped when
// the DUT hands a result over.
// ----------------------------------------------------------------------------
module tb_add_accum_mc;

    localparam int DW = 16;
    localparam int GD = 4;
    localparam int AW = DW + GD;
    localparam int NC = 2;
    localparam int CB = 2;

    localparam longint AMAX = 524287;
    localparam longint AMIN = -524288;
    localparam longint DMAX = 32767;
    localparam longint DMIN = -32768;

    localparam logic [2:0] ACCUM = 3'b000;
    localparam logic [2:0] LOAD  = 3'b001;
    localparam logic [2:0] HOLD  = 3'b010;
    localparam logic [2:0] COMP  = 3'b011;
    localparam logic [2:0] SUB   = 3'b100;
    localparam logic [2:0] CLEAR = 3'b101;
    localparam logic [2:0] READ  = 3'b110;
    localparam logic [2:0] RDCLR = 3'b111;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    control;
    logic [CB-1:0] ch;
    logic [DW-1:0] add_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] acc_out;
    logic [NC-1:0] ovf;

    always #5 clock = ~clock;

    add_accum_mc #(
        .DATA_WIDTH (DW),
        .GUARD      (GD),
        .NUM_CH     (NC),
        .CH_BITS    (CB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .control   (control),
        .ch        (ch),
        .add_in    (add_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .ovf       (ovf)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    longint        m_acc [NC];
    logic [NC-1:0] m_ovf;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] mon_exp;

    int cyc = 0;
    int pop_cnt = 0;
    int last_pop = 0;
    int prev_pop = 0;
    int last_stalls = 0;

    always @(posedge clock) cyc++;

    task automatic model_reset();
        for (int i = 0; i < NC; i++) m_acc[i] = 0;
        m_ovf = '0;
        exp_q.delete();
    endtask

    task automatic wrap_store(input int c, input longint full);
        logic signed [AW-1:0] w;
        w = full[AW-1:0];
        m_acc[c] = w;
        if (full > AMAX || full < AMIN) m_ovf[c] = 1'b1;
    endtask

    task automatic model_apply(input logic [2:0] op, input int c, input logic [DW-1:0] d);
        longint a;
        longint x;
        longint sat;
        if (c >= NC) begin
            if (op == READ || op == RDCLR) exp_q.push_back('0);
            return;
        end
        a = m_acc[c];
        x = longint'($signed(d));
        case (op)
            ACCUM: wrap_store(c, a + x);
            LOAD:  begin m_acc[c] = x; m_ovf[c] = 1'b0; end
            HOLD:  ;
            COMP:  wrap_store(c, 0 - a);
            SUB:   wrap_store(c, a - x);
            CLEAR: begin m_acc[c] = 0; m_ovf[c] = 1'b0; end
            default: begin
                sat = (a > DMAX) ? DMAX : (a < DMIN) ? DMIN : a;
                exp_q.push_back(sat[DW-1:0]);
                if (op == READ) begin
                    if (sat != a) m_ovf[c] = 1'b1;
                end else begin
                    m_acc[c] = 0;
                    m_ovf[c] = 1'b0;
                end
            end
        endcase
    endtask

    // Output monitor: a transfer happens at the next rising edge when
    // out_valid and out_ready are both high at mid-cycle.
    always @(negedge clock) begin
        #2;
        if (!reset && out_valid && out_ready) begin
            chk("out_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                chk("acc_out", acc_out, mon_exp);
            end
            prev_pop = last_pop;
            last_pop = cyc;
            pop_cnt++;
        end
    end

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    task automatic issue(input logic [2:0] op, input int c, input logic [DW-1:0] d,
                         input bit rand_rdy = 1'b0);
        int n;
        bit r;
        r = 1'b0;
        @(negedge clock);
        in_valid = 1'b1;
        control  = op;
        ch       = c[CB-1:0];
        add_in   = d;
        for (n = 0; n < 100; n++) begin
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            #3;
            r = in_ready;
            @(posedge clock);
            if (r) break;
            @(negedge clock);
        end
        last_stalls = n;
        chk("accept_timeout", 32'(r), 1);
        if (r) model_apply(op, c, d);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clock);
            #4;
        end
        chk("drain", exp_q.size(), 0);
        @(posedge clock);
        #1;
    endtask

    task automatic check_ovf(input string tag);
        chk(tag, ovf, m_ovf);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        control   = '0;
        ch        = '0;
        add_in    = '0;
        out_ready = 1'b1;
        model_reset();

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_acc_out", acc_out, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clock);
        reset = 1'b0;

        // Saturating read of a guard-bit value
        issue(LOAD, 0, 16'h7000);
        chk("first_accept_stalls", last_stalls, 0);
        issue(ACCUM, 0, 16'h2000);
        check_ovf("ovf_after_accum");
        issue(READ, 0, '0);
        drain();
        check_ovf("ovf_after_sat_read");

        // Complement on the other channel, channel 0 untouched
        issue(LOAD, 1, 16'd5);
        issue(COMP, 1, '0);
        issue(READ, 1, '0);
        issue(READ, 0, '0);
        drain();
        check_ovf("ovf_after_comp");

        // Output held: held ACCUM must wait and apply exactly once
        out_ready = 1'b0;
        issue(READ, 0, '0);
        fork
            issue(ACCUM, 0, 16'h8000);
            begin
                repeat (3) begin
                    @(negedge clock);
                    #1;
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_acc_out", acc_out, 16'h7FFF);
                end
                @(negedge clock);
                out_ready = 1'b1;
            end
        join
        chk("held_stalls", last_stalls, 3);
        issue(READ, 0, '0);
        drain();

        // READ_CLEAR then READ
        issue(LOAD, 0, 16'h0100);
        issue(RDCLR, 0, '0);
        issue(READ, 0, '0);
        drain();
        check_ovf("ovf_after_rdclr");

        // Back-to-back reads, no bubble
        issue(READ, 0, '0);
        issue(READ, 1, '0);
        drain();
        chk("b2b_gap", last_pop - prev_pop, 1);

        // HOLD, out-of-range channel, CLEAR
        issue(HOLD, 1, 16'h1234);
        issue(READ, 1, '0);
        issue(LOAD, 2, 16'h5555);
        issue(READ, 2, '0);
        issue(READ, 3, '0);
        issue(READ, 1, '0);
        issue(CLEAR, 1, '0);
        issue(READ, 1, '0);
        drain();
        check_ovf("ovf_after_misc");

        // Reach the most negative value exactly, then complement it
        issue(CLEAR, 0, '0);
        repeat (16) issue(ACCUM, 0, 16'h8000);
        check_ovf("ovf_at_min");
        issue(COMP, 0, '0);
        check_ovf("ovf_comp_min");
        issue(RDCLR, 0, '0);
        drain();
        check_ovf("ovf_rdclr_sat");

        // Positive wrap and negative subtract
        for (int i = 0; i < 17; i++) begin
            issue(ACCUM, 0, 16'h7FFF);
            check_ovf("ovf_accum_walk");
        end
        issue(READ, 0, '0);
        issue(LOAD, 1, 16'h0001);
        issue(SUB, 1, 16'h7FFF);
        issue(READ, 1, '0);
        drain();
        check_ovf("ovf_after_sub");

        // Random traffic with random consumer back-pressure
        for (int i = 0; i < 150; i++) begin
            issue(3'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  16'($urandom), 1'b1);
            check_ovf("ovf_random");
        end
        out_ready = 1'b1;
        drain();

        // Reset while a result is pending
        out_ready = 1'b0;
        issue(LOAD, 1, 16'h0042);
        issue(READ, 1, '0);
        @(negedge clock);
        reset = 1'b1;
        in_valid = 1'b1;
        control  = LOAD;
        ch       = 2'd1;
        add_in   = 16'h7777;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_acc_out", acc_out, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_in_ready", in_ready, 1);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        in_valid  = 1'b0;
        reset     = 1'b0;
        out_ready = 1'b1;
        issue(READ, 0, '0);
        chk("post_rst_stalls", last_stalls, 0);
        issue(READ, 1, '0);
        drain();
        check_ovf("ovf_post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0x1 expected 0x0");
        $fatal(1, "timeout");
    end

endmodule
